// File: rtl/calc_op_sequencer.sv
// Registered valid/ready front end for the calculator units: result valid SETTLE_CYCLES edges after accept (next edge for an illegal op),
// held stable under out_ready backpressure, one op in flight. Define CALC_NEG_ZERO_NORM_EN to store a sampled -0 (100) as +0 (000).
module calc_op_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_op,
  input  logic [2:0] in_a,
  input  logic [2:0] in_b,
  output logic [2:0] op_a,
  output logic [2:0] op_b,
  output logic [2:0] op_code,
  input  logic [2:0] unit_result,
  input  logic [2:0] unit_sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_result,
  output logic       err_op,
  output logic       err_sel,
  output logic       div_zero
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       legal_op;
  logic       div_by_zero;
  logic [2:0] sampled_result;

  assign legal_op    = (in_op <= 3'b100);
  assign div_by_zero = ((op_code == 3'b011) || (op_code == 3'b100)) && (op_b[1:0] == 2'b00);

`ifdef CALC_NEG_ZERO_NORM_EN
  assign sampled_result = (unit_result == 3'b100) ? 3'b000 : unit_result;
`else
  assign sampled_result = unit_result;
`endif

  // in_ready is a flop so it stays low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      cnt        <= 4'd0;
      op_a       <= 3'b000;
      op_b       <= 3'b000;
      op_code    <= 3'b000;
      out_valid  <= 1'b0;
      out_result <= 3'b000;
      err_op     <= 1'b0;
      err_sel    <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            op_a     <= in_a;
            op_b     <= in_b;
            op_code  <= in_op;
            if (legal_op) begin
              cnt   <= CNT_INIT;
              state <= SETTLE;
            end else begin
              out_result <= 3'b000;
              err_op     <= 1'b1;
              err_sel    <= 1'b0;
              div_zero   <= 1'b0;
              out_valid  <= 1'b1;
              state      <= HOLD;
            end
          end
        end
        SETTLE: begin
          if (cnt == 4'd0) begin
            out_result <= sampled_result;
            err_sel    <= (unit_sel != op_code);
            div_zero   <= div_by_zero;
            err_op     <= 1'b0;
            out_valid  <= 1'b1;
            state      <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/calc_op_sequencer.md
# calc_op_sequencer

Registered front end for the signed calculator's combinational arithmetic units (add, sub, mul, div, remainder). It accepts one operation at a time over a valid/ready handshake and drives the captured 3-bit sign-magnitude operands onto the shared unit bus. After a configurable settle time it samples the selected unit's `Result` and `Selection`, then presents a registered result with status flags downstream.

## Interface
- `SETTLE_CYCLES`, default 1: cycles operands are held on the unit bus before sampling; legal range 1–15.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  request present
- `in_ready`  out  1  block can accept a request
- `in_op`  in  3  op code: 000 add, 001 sub, 010 mul, 011 div, 100 remainder; 101–111 illegal
- `in_a`, `in_b`  in  3 each  operands; bit 2 = sign, bits 1:0 = magnitude
- `op_a`, `op_b`  out  3 each  registered operands to all units (`A`, `B`)
- `op_code`  out  3  registered op code; steers the unit result mux
- `unit_result`  in  3  `Result` of the selected unit
- `unit_sel`  in  3  `Selection` reported by the selected unit
- `out_valid`  out  1  result available
- `out_ready`  in  1  downstream accepts result
- `out_result`  out  3  registered sign-magnitude result
- `err_op`  out  1  illegal op code
- `err_sel`  out  1  `unit_sel` did not equal the captured op code at sample time
- `div_zero`  out  1  op 011/100 with `in_b[1:0]` = 00; covers both +0 (000) and −0 (100)

## Operation
- FSM states: IDLE, SETTLE, HOLD.
- IDLE: `in_ready` = 1.
  - On `in_valid && in_ready`, capture `in_op`/`in_a`/`in_b` into `op_code`/`op_a`/`op_b`.
  - Legal op: load settle counter with `SETTLE_CYCLES`−1 and go to SETTLE.
  - Illegal op: do not enter SETTLE. Set `out_result` = 000, `err_op` = 1, `err_sel` = 0, `div_zero` = 0, `out_valid` = 1, go to HOLD.
- SETTLE: `in_ready` = 0; counter decrements each cycle.
  - When the counter is 0, on that edge:
    - sample `unit_result` into `out_result`;
    - set `err_sel` = (`unit_sel` != `op_code`);
    - set `div_zero` from the captured operands;
    - clear `err_op`;
    - set `out_valid` = 1 and go to HOLD.
- HOLD: `in_ready` = 0.
  - `out_result`, flags, `op_a`, `op_b` and `op_code` stay stable while `out_valid && !out_ready`.
  - On `out_valid && out_ready`: clear `out_valid` and go to IDLE. Result and flags keep their values until the next capture.
- Flags never suppress the result. On divide-by-zero, whatever the unit returns is passed through (the remainder unit returns sign of A with magnitude 00).
- `in_valid` while `in_ready` = 0 is ignored; no queuing.
- Reset (async, any state):
  - state goes to IDLE;
  - `in_ready` = 0 while `rst_n` is low, then 1 from the first cycle after release;
  - `out_valid`, `out_result`, `op_a`, `op_b`, `op_code`, `err_op`, `err_sel`, `div_zero` all go to 0;
  - an in-flight operation is discarded with no partial output.

## Timing
- Request accepted at edge E0. Operands are valid on `op_a`/`op_b` right after E0.
- Legal op: `unit_result` is sampled at edge E0+`SETTLE_CYCLES`, and `out_valid` rises right after that edge.
- Illegal op: `out_valid` rises right after E0.
- Result handshake at edge E1 puts the block back in IDLE, so `in_ready` = 1 right after E1.
- Peak throughput is one op per `SETTLE_CYCLES`+2 cycles (`out_ready` tied high).
- `out_ready` high at the cycle `out_valid` first rises completes the handshake at the next edge.

## Configuration
- `CALC_NEG_ZERO_NORM_EN` defined: a sampled `unit_result` of 100 (−0) is stored as 000 in `out_result`.
- Not defined: `unit_result` is stored unmodified, so −0 (100) passes through.
- Flags are unaffected either way.

## Test plan
- Remainder, `SETTLE_CYCLES`=1: op 100, a=011, b=010; unit returns result 001, sel 100; `out_ready`=1. Expect `out_valid` one edge after accept, `out_result`=001, all flags 0, `in_ready` back to 1 two edges after accept.
- Negative zero: op 100, a=110, b=001, unit returns 100. With `CALC_NEG_ZERO_NORM_EN`: `out_result`=000. Without: `out_result`=100.
- Divide by zero: op 011 with b=000, then op 100 with b=100. Expect `div_zero`=1 both times, `out_result` equal to `unit_result`, `err_sel`=0 when sel matches.
- Illegal op and sel mismatch:
  - op 110: expect `out_valid` right after accept, `out_result`=000, `err_op`=1, `unit_result` ignored.
  - op 010 with unit sel 011: expect `err_sel`=1.
- Back-pressure: hold `out_ready`=0 for 5 cycles while toggling `unit_result` and asserting `in_valid` with new data. Expect outputs stable, `in_ready`=0, no new capture; release and expect the handshake then IDLE.
- Reset mid-op, `SETTLE_CYCLES`=4: pull `rst_n` low 2 cycles after accept. Expect immediate zeroed outputs, `out_valid` never asserted, and a fresh op after release completes normally.
